man_datapath: RTL and testbench
===============================

Name: man_datapath

Overview:
- Datapath directly downstream of the game control FSM. It consumes ld_x/ld_y/ld_man_style/update/draw_man/erase and returns draw_man_finish, erase_finish, x_w, y_w and crouch.
- Holds the running man's lane, jump arc and crouch state. Scans the man's bounding box as a stream of pixel coordinates and colours for the VGA writer.
- Screen is 160x120, with 8-bit x and 7-bit y. Lane 0 is the top floor, lane 2 the bottom floor.

Parameters:
- MAN_X, 20: fixed left column of the man.
- MAN_W, 8: sprite width in pixels.
- MAN_H, 12: standing sprite height.
- CROUCH_H, 6: crouched sprite height.
- LANE0_Y, 39: feet row on lane 0.
- LANE1_Y, 79: feet row on lane 1.
- LANE2_Y, 119: feet row on lane 2.
- JUMP_H, 10: peak jump offset in rows, reached one row per update.
- MAN_COLOUR, 3'b111: draw colour.
- BG_COLOUR, 3'b000: erase colour.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- ld_x, ld_y  in  1  latch the current x or y into the draw origin.
- ld_man_style  in  1  latch the current height (standing or crouched) into draw_h.
- update  in  1  one-cycle pulse that advances position by one step.
- draw_man  in  1  held high while the sprite scan runs.
- erase  in  1  held high while the background scan runs.
- key_up, key_down, key_jump  in  1  level inputs, synchronised upstream.
- key_crouch  in  1  level input, crouch held.
- x_w  out  8  live x (always MAN_X).
- y_w  out  7  live feet row.
- crouch  out  1  live crouch state.
- pix_x  out  8  pixel x.
- pix_y  out  7  pixel y.
- pix_colour  out  3  pixel colour.
- draw_man_finish  out  1  high during the last draw pixel.
- erase_finish  out  1  high during the last erase pixel.

Behaviour:
- Reset values:
  - lane=2, jump state GROUND, offset=0, crouch=0, all pending requests 0.
  - Draw origin org_x=MAN_X, org_y=LANE2_Y-MAN_H+1, draw_h=MAN_H.
  - Scan counters col=0, row=0. Both finish outputs 0.
  - pix_x=MAN_X, pix_y=org_y, pix_colour=BG_COLOUR.
- Key capture:
  - A rising edge of key_up, key_down or key_jump sets the matching pending flag.
  - The flag stays set until the next update pulse, then clears regardless of whether it took effect.
  - key_crouch is sampled as a level at the update pulse.
- Jump FSM, which advances only on update:
  - GROUND -> RISE if jump pending. This update already applies offset=1.
  - RISE: offset+1 per update. Offset reaching JUMP_H -> FALL.
  - FALL: offset-1 per update. Offset reaching 0 -> GROUND.
  - One full arc is 2*JUMP_H updates from the jump update back to GROUND.
- Lane changes on update, GROUND only:
  - up: lane-1, saturating at 0. down: lane+1, saturating at 2.
  - If up and down are both pending, neither applies.
  - If jump and a lane change are both pending, jump wins and the lane change is dropped.
  - Requests made while airborne are dropped.
- Crouch register:
  - On update, crouch = key_crouch AND (next state == GROUND).
  - A jump request clears crouch.
- Derived values:
  - y_w = LANE_Y[lane] - offset, in 7-bit unsigned arithmetic. Defaults guarantee no underflow.
  - h = crouch ? CROUCH_H : MAN_H.
- Latching draw origin:
  - ld_y loads org_y = y_w - h + 1 and ld_man_style loads draw_h = h, both from the live values that same cycle.
  - ld_x loads org_x = x_w.
  - Origin registers are unaffected by update, so erase always clears the box that was last drawn.
- Scan:
  - Active when draw_man or erase is high. Erase has priority if both are high.
  - Outputs are combinational from the counters: pix_x=org_x+col, pix_y=org_y+row.
  - pix_colour is MAN_COLOUR when drawing, BG_COLOUR when erasing.
  - col increments each cycle; at MAN_W-1 it wraps to 0 and row increments.
- Scan limits and completion:
  - Draw limit is draw_h rows. Erase limit is always MAN_H rows, starting at org_y+draw_h-MAN_H, so a crouched box is fully cleared.
  - The matching finish output is high combinationally in the cycle col==MAN_W-1 and row==limit-1. Counters return to 0 on that edge.
  - The scan therefore spans exactly MAN_W*limit cycles.
- Scan abort: when neither draw_man nor erase is high, counters hold 0 and both finish outputs are 0. Deasserting mid-scan aborts the scan, and the next scan restarts at (0,0).
- Reset: reset mid-scan or mid-jump returns every register to its reset value on the next edge.

Test Plan:
- Reset, then hold draw_man -> 96 cycles with pix spanning x 20..27, y 108..119, colour 7. draw_man_finish is high only on cycle 96, at pix (27,119).
- key_up edge, update pulse, ld_x/ld_y/ld_man_style, then draw -> y_w=79, org_y=68. A second up reaches lane 0 (y_w=39). A third up stays at 39.
- key_jump edge, then 20 update pulses -> y_w sequence 118..109 reaching 109 at update 10, then 110..119. Jump FSM returns to GROUND. key_down presses in between are ignored.
- key_crouch held plus update, ld, draw -> crouch=1, draw scan 48 cycles at y 114..119. Then erase -> 96 cycles covering y 108..119 with colour 0.
- Draw, then update with lane up, then erase without ld -> erase still covers y 108..119. x_w/y_w already show (20,79).
- reset_n low at draw cycle 40 -> next cycle counters=0, finishes=0, lane=2. A fresh draw again takes 96 cycles.

Source files
------------

// File: rtl/man_datapath_if.sv
// Control/status and pixel-stream bundle between the game control FSM,
// the man datapath and the VGA writer.
interface man_datapath_if;
    logic       ld_x;
    logic       ld_y;
    logic       ld_man_style;
    logic       update;
    logic       draw_man;
    logic       erase;
    logic       draw_man_finish;
    logic       erase_finish;
    logic [7:0] x_w;
    logic [6:0] y_w;
    logic       crouch;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_colour;

    modport master (
        output ld_x, ld_y, ld_man_style, update, draw_man, erase,
        input  draw_man_finish, erase_finish, x_w, y_w, crouch,
        input  pix_x, pix_y, pix_colour
    );

    modport slave (
        input  ld_x, ld_y, ld_man_style, update, draw_man, erase,
        output draw_man_finish, erase_finish, x_w, y_w, crouch,
        output pix_x, pix_y, pix_colour
    );
endinterface

// File: rtl/man_datapath.sv
// Running-man datapath: lane, jump arc and crouch state, plus a scan of the
// man's bounding box as a pixel stream for the VGA writer.
module man_datapath #(
    parameter int         MAN_X      = 20,
    parameter int         MAN_W      = 8,
    parameter int         MAN_H      = 12,
    parameter int         CROUCH_H   = 6,
    parameter int         LANE0_Y    = 39,
    parameter int         LANE1_Y    = 79,
    parameter int         LANE2_Y    = 119,
    parameter int         JUMP_H     = 10,
    parameter logic [2:0] MAN_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR  = 3'b000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_up,
    input  logic key_down,
    input  logic key_jump,
    input  logic key_crouch,
    man_datapath_if.slave bus
);

    localparam int COL_W = $clog2(MAN_W);
    localparam int ROW_W = $clog2(MAN_H + 1);
    localparam int OFF_W = $clog2(JUMP_H + 1);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } jump_state_t;

    jump_state_t        state;
    logic [1:0]         lane;
    logic [OFF_W-1:0]   offset;
    logic               crouch_r;
    logic               up_q, down_q, jump_q;
    logic               up_p, down_p, jump_p;
    logic               up_rise, down_rise, jump_rise;
    logic               lands_ground;

    logic [7:0]         org_x;
    logic [6:0]         org_y;
    logic [ROW_W-1:0]   draw_h;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;

    logic [6:0]         y_now;
    logic [ROW_W-1:0]   h_now;
    logic               active, erasing, drawing, last_col, last_pix;
    logic [ROW_W-1:0]   limit;
    logic [6:0]         base_y;

    function automatic logic [6:0] lane_y(input logic [1:0] l);
        case (l)
            2'd0:    lane_y = 7'(LANE0_Y);
            2'd1:    lane_y = 7'(LANE1_Y);
            default: lane_y = 7'(LANE2_Y);
        endcase
    endfunction

    assign up_rise   = key_up & ~up_q;
    assign down_rise = key_down & ~down_q;
    assign jump_rise = key_jump & ~jump_q;

    // True when this update leaves the man on the ground: either he stays
    // there without jumping, or the fall completes on this step.
    assign lands_ground = ((state == GROUND) && !jump_p) ||
                          ((state == FALL) && (offset == OFF_W'(1)));

    assign y_now = lane_y(lane) - 7'(offset);
    assign h_now = crouch_r ? ROW_W'(CROUCH_H) : ROW_W'(MAN_H);

    assign bus.x_w    = 8'(MAN_X);
    assign bus.y_w    = y_now;
    assign bus.crouch = crouch_r;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= GROUND;
            lane     <= 2'd2;
            offset   <= '0;
            crouch_r <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            jump_q   <= 1'b0;
            up_p     <= 1'b0;
            down_p   <= 1'b0;
            jump_p   <= 1'b0;
        end else begin
            up_q   <= key_up;
            down_q <= key_down;
            jump_q <= key_jump;
            if (bus.update) begin
                // Requests are consumed by every update; an edge arriving in
                // the same cycle is kept for the following update.
                up_p     <= up_rise;
                down_p   <= down_rise;
                jump_p   <= jump_rise;
                crouch_r <= key_crouch & lands_ground & ~jump_p;
                case (state)
                    GROUND: begin
                        if (jump_p) begin
                            state  <= RISE;
                            offset <= OFF_W'(1);
                        end else if (up_p && !down_p) begin
                            if (lane != 2'd0) lane <= lane - 2'd1;
                        end else if (down_p && !up_p) begin
                            if (lane != 2'd2) lane <= lane + 2'd1;
                        end
                    end
                    RISE: begin
                        offset <= offset + OFF_W'(1);
                        if (offset == OFF_W'(JUMP_H - 1)) state <= FALL;
                    end
                    FALL: begin
                        offset <= offset - OFF_W'(1);
                        if (offset == OFF_W'(1)) state <= GROUND;
                    end
                    default: state <= GROUND;
                endcase
            end else begin
                up_p   <= up_p | up_rise;
                down_p <= down_p | down_rise;
                jump_p <= jump_p | jump_rise;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            org_x  <= 8'(MAN_X);
            org_y  <= 7'(LANE2_Y - MAN_H + 1);
            draw_h <= ROW_W'(MAN_H);
        end else begin
            if (bus.ld_x)         org_x  <= 8'(MAN_X);
            if (bus.ld_y)         org_y  <= y_now - 7'(h_now) + 7'd1;
            if (bus.ld_man_style) draw_h <= h_now;
        end
    end

    // Erase always clears a full standing box anchored at the drawn feet row,
    // so a crouched sprite and the rows above it are both wiped.
    assign active   = bus.draw_man | bus.erase;
    assign erasing  = bus.erase;
    assign drawing  = bus.draw_man & ~bus.erase;
    assign limit    = erasing ? ROW_W'(MAN_H) : draw_h;
    assign base_y   = erasing ? (org_y + 7'(draw_h) - 7'(MAN_H)) : org_y;
    assign last_col = (col == COL_W'(MAN_W - 1));
    assign last_pix = active && last_col && (row == limit - ROW_W'(1));

    assign bus.pix_x           = org_x + 8'(col);
    assign bus.pix_y           = base_y + 7'(row);
    assign bus.pix_colour      = drawing ? MAN_COLOUR : BG_COLOUR;
    assign bus.draw_man_finish = drawing & last_pix;
    assign bus.erase_finish    = erasing & last_pix;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else if (!active || last_pix) begin
            col <= '0;
            row <= '0;
        end else if (last_col) begin
            col <= '0;
            row <= row + ROW_W'(1);
        end else begin
            col <= col + COL_W'(1);
        end
    end

endmodule

// File: tb/tb_man_datapath.sv
// Self-checking bench for man_datapath: constant vector table, hand-written
// scan/jump/reset sequences and randomized moves against a reference model.
module tb_man_datapath;

    logic clk = 1'b0;
    logic reset_n;
    logic key_up, key_down, key_jump, key_crouch;

    man_datapath_if bus();

    man_datapath dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_up     (key_up),
        .key_down   (key_down),
        .key_jump   (key_jump),
        .key_crouch (key_crouch),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: lane index, steps taken since the jump began (0 means
    // on the ground), pending requests and the latched draw box.
    int m_lane, m_step, m_orgy, m_drawh;
    bit m_crouch, m_pu, m_pd, m_pj;

    typedef struct {
        bit up;
        bit down;
        bit jump;
        bit crouch;
        int exp_y;
        bit exp_crouch;
    } vec_t;

    vec_t tbl[$];

    function automatic int modelY();
        int base;
        int off;
        base = (m_lane == 0) ? 39 : (m_lane == 1) ? 79 : 119;
        off  = (m_step <= 10) ? m_step : 20 - m_step;
        return base - off;
    endfunction

    function automatic int modelH();
        return m_crouch ? 6 : 12;
    endfunction

    task automatic modelReset();
        m_lane = 2; m_step = 0; m_crouch = 0;
        m_pu = 0; m_pd = 0; m_pj = 0;
        m_orgy = 108; m_drawh = 12;
    endtask

    task automatic modelUpdate(input bit kc);
        if (m_step != 0) begin
            m_step++;
            if (m_step == 20) m_step = 0;
        end else if (m_pj) begin
            m_step = 1;
        end else if (m_pu && !m_pd) begin
            if (m_lane > 0) m_lane--;
        end else if (m_pd && !m_pu) begin
            if (m_lane < 2) m_lane++;
        end
        m_crouch = kc && (m_step == 0) && !m_pj;
        m_pu = 0; m_pd = 0; m_pj = 0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic doUpdate();
        bus.update = 1'b1;
        tick();
        bus.update = 1'b0;
        modelUpdate(key_crouch);
        #1;
        checkOutput("x_w", bus.x_w, 20);
        checkOutput("y_w", bus.y_w, modelY());
        checkOutput("crouch", bus.crouch, m_crouch);
    endtask

    task automatic applyStimulus(input bit up, input bit down, input bit jump, input bit kc);
        key_crouch = kc;
        if (up || down || jump) begin
            key_up = up; key_down = down; key_jump = jump;
            tick();
            m_pu |= up; m_pd |= down; m_pj |= jump;
            key_up = 0; key_down = 0; key_jump = 0;
            tick();
        end
        doUpdate();
    endtask

    task automatic doLoad();
        bus.ld_x = 1; bus.ld_y = 1; bus.ld_man_style = 1;
        tick();
        bus.ld_x = 0; bus.ld_y = 0; bus.ld_man_style = 0;
        m_orgy  = modelY() - modelH() + 1;
        m_drawh = modelH();
    endtask

    // Runs a scan for n cycles (0 = the whole box) and checks every pixel.
    task automatic runScan(input bit er, input int n, input string tag);
        int limit, base, total, cycles;
        logic [19:0] expv, actv;
        limit  = er ? 12 : m_drawh;
        base   = er ? m_orgy + m_drawh - 12 : m_orgy;
        total  = 8 * limit;
        cycles = (n == 0) ? total : n;
        if (er) bus.erase = 1; else bus.draw_man = 1;
        #1;
        for (int k = 0; k < cycles; k++) begin
            expv = {8'(20 + k % 8), 7'(base + k / 8), er ? 3'd0 : 3'd7,
                    (!er && k == total - 1), (er && k == total - 1)};
            actv = {bus.pix_x, bus.pix_y, bus.pix_colour,
                    bus.draw_man_finish, bus.erase_finish};
            checkOutput(tag, actv, expv);
            tick();
        end
        bus.draw_man = 0; bus.erase = 0;
        #1;
        checkOutput({tag, " idle"}, {bus.draw_man_finish, bus.erase_finish}, 0);
        tick();
    endtask

    initial begin
        reset_n = 0;
        key_up = 0; key_down = 0; key_jump = 0; key_crouch = 0;
        bus.ld_x = 0; bus.ld_y = 0; bus.ld_man_style = 0;
        bus.update = 0; bus.draw_man = 0; bus.erase = 0;
        modelReset();
        repeat (3) tick();
        reset_n = 1;
        #1;
        checkOutput("rst x_w", bus.x_w, 20);
        checkOutput("rst y_w", bus.y_w, 119);
        checkOutput("rst crouch", bus.crouch, 0);
        checkOutput("rst pix", {bus.pix_x, bus.pix_y, bus.pix_colour}, {8'd20, 7'd108, 3'd0});
        checkOutput("rst fin", {bus.draw_man_finish, bus.erase_finish}, 0);
        tick();

        runScan(0, 0, "draw reset box");

        tbl.push_back('{1, 0, 0, 0, 79, 0});
        tbl.push_back('{1, 0, 0, 0, 39, 0});
        tbl.push_back('{1, 0, 0, 0, 39, 0});
        tbl.push_back('{0, 1, 0, 0, 79, 0});
        tbl.push_back('{1, 1, 0, 0, 79, 0});
        tbl.push_back('{0, 1, 0, 0, 119, 0});
        tbl.push_back('{0, 1, 0, 0, 119, 0});
        tbl.push_back('{0, 0, 0, 1, 119, 1});
        tbl.push_back('{0, 0, 0, 0, 119, 0});
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].up, tbl[i].down, tbl[i].jump, tbl[i].crouch);
            checkOutput($sformatf("tbl%0d y", i), bus.y_w, tbl[i].exp_y);
            checkOutput($sformatf("tbl%0d crouch", i), bus.crouch, tbl[i].exp_crouch);
        end

        applyStimulus(1, 0, 0, 0);
        doLoad();
        runScan(0, 0, "draw lane1");
        applyStimulus(0, 1, 0, 0);

        // Jump beats a simultaneous lane change; airborne requests are lost.
        applyStimulus(1, 0, 1, 0);
        checkOutput("jump step1", bus.y_w, 118);
        for (int i = 2; i <= 20; i++) begin
            applyStimulus(i % 3 == 0, i % 3 == 1, i % 5 == 0, 0);
            checkOutput($sformatf("arc %0d", i), bus.y_w, 119 - ((i <= 10) ? i : 20 - i));
        end
        applyStimulus(1, 0, 0, 0);
        checkOutput("landed lane move", bus.y_w, 79);
        applyStimulus(0, 1, 0, 0);

        applyStimulus(0, 0, 0, 1);
        doLoad();
        runScan(0, 0, "draw crouch");
        runScan(1, 0, "erase crouch");
        applyStimulus(0, 0, 0, 0);
        doLoad();

        runScan(0, 0, "draw pre-move");
        applyStimulus(1, 0, 0, 0);
        checkOutput("moved y_w", bus.y_w, 79);
        runScan(1, 0, "erase stale box");

        runScan(0, 10, "draw abort");
        runScan(0, 0, "draw restart");

        applyStimulus(0, 0, 0, 1);
        doLoad();
        bus.draw_man = 1;
        repeat (40) tick();
        reset_n = 0;
        tick();
        #1;
        checkOutput("mid rst pix", {bus.pix_x, bus.pix_y}, {8'd20, 7'd108});
        checkOutput("mid rst fin", {bus.draw_man_finish, bus.erase_finish}, 0);
        checkOutput("mid rst y_w", bus.y_w, 119);
        checkOutput("mid rst crouch", bus.crouch, 0);
        reset_n = 1;
        bus.draw_man = 0;
        key_crouch = 0;
        modelReset();
        tick();
        runScan(0, 0, "draw after rst");

        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 5);
            if (r < 4) begin
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            end else if (r == 4) begin
                doLoad();
                runScan(0, 0, "rand draw");
            end else begin
                runScan(1, 0, "rand erase");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
